// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU issue definitions: ALU control codes, MIPS opcode/funct values
// and the decoder result record.
package alu_defs;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;

    // Which instruction field names the writeback register.
    typedef enum logic [1:0] {
        DEST_ZERO = 2'd0,
        DEST_RD   = 2'd1,
        DEST_RT   = 2'd2
    } dest_sel_e;

    typedef struct packed {
        logic [2:0] alu_control;
        logic       imm_sel;    // operand B is the immediate, not rt_data
        logic       zero_ext;   // immediate is zero-extended (logical ops)
        dest_sel_e  dest_sel;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// ALU-side bus of the issue stage: operands, control and valid/ready.
// master = issue stage (drives operands), slave = EX/MEM consumer.
interface alu_issue_if #(parameter int DATA_W = 32);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] Read_data_1;
    logic [DATA_W-1:0] Data_2;
    logic [2:0]        ALU_control;
    logic [4:0]        dest_reg;
    logic              illegal;

    modport master (output out_valid, Read_data_1, Data_2, ALU_control, dest_reg, illegal,
                    input  out_ready);
    modport slave  (input  out_valid, Read_data_1, Data_2, ALU_control, dest_reg, illegal,
                    output out_ready);
endinterface

// File: rtl/alu_issue_stage_ctrl.sv
// Combinational MIPS decoder: opcode/funct -> ALU control, operand B
// selection, writeback register selection and an unsupported flag.
module alu_ctrl_decode
    import alu_defs::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec
);

    // Unknown encodings fall through to the default: ADD, no dest, illegal.
    always_comb begin
        dec = '{alu_control: ALU_ADD, imm_sel: 1'b0, zero_ext: 1'b0,
                dest_sel: DEST_ZERO, illegal: 1'b1};
        unique case (opcode)
            OP_RTYPE: begin
                dec.dest_sel = DEST_RD;
                dec.illegal  = 1'b0;
                case (funct)
                    F_ADD, F_ADDU: dec.alu_control = ALU_ADD;
                    F_SUB, F_SUBU: dec.alu_control = ALU_SUB;
                    F_AND:         dec.alu_control = ALU_AND;
                    F_OR:          dec.alu_control = ALU_OR;
                    F_SLT:         dec.alu_control = ALU_SLT;
                    default: begin
                        dec.dest_sel = DEST_ZERO;
                        dec.illegal  = 1'b1;
                    end
                endcase
            end
            OP_LW, OP_ADDI: begin
                dec = '{ALU_ADD, 1'b1, 1'b0, DEST_RT, 1'b0};
            end
            OP_SW: begin
                dec = '{ALU_ADD, 1'b1, 1'b0, DEST_ZERO, 1'b0};
            end
            OP_SLTI: begin
                dec = '{ALU_SLT, 1'b1, 1'b0, DEST_RT, 1'b0};
            end
            OP_ANDI: begin
                dec = '{ALU_AND, 1'b1, 1'b1, DEST_RT, 1'b0};
            end
            OP_ORI: begin
                dec = '{ALU_OR, 1'b1, 1'b1, DEST_RT, 1'b0};
            end
            OP_BEQ: begin
                dec = '{ALU_SUB, 1'b0, 1'b0, DEST_ZERO, 1'b0};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes the instruction, registers ALU operands and
// control in a single valid/ready slot with flush, and counts issued ops.
module alu_issue_stage
    import alu_defs::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              flush,
    alu_issue_if.master       alu,
    output logic [CNT_W-1:0]  issue_count
);

    dec_t              dec;
    logic              accept;
    logic [DATA_W-1:0] imm_ext;
    logic              valid_q, illegal_q;
    logic [DATA_W-1:0] rd1_q, d2_q;
    logic [2:0]        ctrl_q;
    logic [4:0]        dest_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              unused_instr;

    // rs field and shamt are not needed: operand A arrives as rs_data.
    assign unused_instr = &{1'b0, instr[25:21], instr[10:6]};

    alu_ctrl_decode u_dec (
        .opcode (instr[31:26]),
        .funct  (instr[5:0]),
        .dec    (dec)
    );

    assign imm_ext  = dec.zero_ext ? {{(DATA_W-16){1'b0}}, instr[15:0]}
                                   : {{(DATA_W-16){instr[15]}}, instr[15:0]};
    // Held low during reset so the ID stage never hands over an op that
    // would be discarded.
    assign in_ready = !reset && (!valid_q || alu.out_ready);
    assign accept   = in_valid && in_ready && !flush;

    // Pipeline slot: reset > flush > accept (incl. drain+accept) > drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            rd1_q     <= '0;
            d2_q      <= '0;
            ctrl_q    <= ALU_ADD;
            dest_q    <= '0;
            cnt_q     <= '0;
        end else if (flush) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            valid_q   <= 1'b1;
            illegal_q <= dec.illegal;
            ctrl_q    <= dec.alu_control;
            if (dec.illegal) begin
                // Bubble: carries no operands so EX computes a harmless 0+0.
                rd1_q  <= '0;
                d2_q   <= '0;
                dest_q <= '0;
            end else begin
                rd1_q  <= rs_data;
                d2_q   <= dec.imm_sel ? imm_ext : rt_data;
                unique case (dec.dest_sel)
                    DEST_RD: dest_q <= instr[15:11];
                    DEST_RT: dest_q <= instr[20:16];
                    default: dest_q <= '0;
                endcase
                if (cnt_q != '1)
                    cnt_q <= cnt_q + 1'b1;
            end
        end else if (alu.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign alu.out_valid   = valid_q;
    assign alu.illegal     = illegal_q;
    assign alu.Read_data_1 = rd1_q;
    assign alu.Data_2      = d2_q;
    assign alu.ALU_control = ctrl_q;
    assign alu.dest_reg    = dest_q;
    assign issue_count     = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: cycle model of the handshake and
// decode rules compared every cycle, plus literal expectations per vector.
module tb_alu_issue_stage;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset, in_valid, flush;
    logic          in_ready;
    logic [31:0]   instr;
    logic [DW-1:0] rs_data, rt_data;
    logic [CW-1:0] issue_count;

    int errors = 0;
    int checks = 0;
    bit model_on = 1'b0;

    alu_issue_if #(.DATA_W(DW)) bus ();

    alu_issue_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
        .alu(bus.master), .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_valid, m_ill;
    logic [31:0] m_rd1, m_d2;
    logic [2:0]  m_ctrl;
    logic [4:0]  m_dest;
    int          m_cnt;

    // Spec-level decode: returns {legal, ctrl, operand B, dest}.
    task automatic spec_decode(input logic [31:0] ins, input logic [31:0] rt,
                               output bit legal, output logic [2:0] c,
                               output logic [31:0] b, output logic [4:0] d);
        logic [31:0] sx, zx;
        logic [5:0]  op, fn;
        op = ins[31:26]; fn = ins[5:0];
        sx = {{16{ins[15]}}, ins[15:0]};
        zx = {16'h0, ins[15:0]};
        legal = 1; c = 3'd2; b = 0; d = 0;
        if (op == 6'h00) begin
            b = rt; d = ins[15:11];
            if (fn == 6'h20 || fn == 6'h21) c = 3'd2;
            else if (fn == 6'h22 || fn == 6'h23) c = 3'd6;
            else if (fn == 6'h24) c = 3'd0;
            else if (fn == 6'h25) c = 3'd1;
            else if (fn == 6'h2A) c = 3'd7;
            else legal = 0;
        end
        else if (op == 6'h23 || op == 6'h08) begin c = 3'd2; b = sx; d = ins[20:16]; end
        else if (op == 6'h2B) begin c = 3'd2; b = sx; d = 0; end
        else if (op == 6'h0A) begin c = 3'd7; b = sx; d = ins[20:16]; end
        else if (op == 6'h0C) begin c = 3'd0; b = zx; d = ins[20:16]; end
        else if (op == 6'h0D) begin c = 3'd1; b = zx; d = ins[20:16]; end
        else if (op == 6'h04) begin c = 3'd6; b = rt; d = 0; end
        else legal = 0;
    endtask

    always @(posedge clk) begin
        bit lg; logic [2:0] c; logic [31:0] b; logic [4:0] d;
        if (reset) begin
            m_valid = 0; m_ill = 0; m_rd1 = 0; m_d2 = 0; m_ctrl = 3'd2; m_dest = 0; m_cnt = 0;
        end else if (flush) begin
            m_valid = 0; m_ill = 0;
        end else if (in_valid && (!m_valid || bus.out_ready)) begin
            spec_decode(instr, rt_data, lg, c, b, d);
            m_valid = 1;
            m_ill   = !lg;
            m_ctrl  = c;
            m_rd1   = lg ? rs_data : 32'h0;
            m_d2    = lg ? b : 32'h0;
            m_dest  = lg ? d : 5'h0;
            if (lg) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
        end else if (m_valid && bus.out_ready) begin
            m_valid = 0;
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (model_on) begin
            chk("m_in_ready", in_ready, !reset && (!m_valid || bus.out_ready));
            chk("m_out_valid", bus.out_valid, m_valid);
            chk("m_count", issue_count, m_cnt);
            chk("m_ctrl", bus.ALU_control, m_ctrl);
            chk("m_rd1", bus.Read_data_1, m_rd1);
            chk("m_d2", bus.Data_2, m_d2);
            chk("m_dest", bus.dest_reg, m_dest);
            if (m_valid) chk("m_illegal", bus.illegal, m_ill);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk); #2;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        in_valid = 1; instr = ins; rs_data = rs; rt_data = rt;
    endtask

    task automatic expect_out(input string n, input logic [2:0] c, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] d, input int cnt);
        chk({n, "_valid"}, bus.out_valid, 1);
        chk({n, "_ctrl"}, bus.ALU_control, c);
        chk({n, "_rd1"}, bus.Read_data_1, a);
        chk({n, "_d2"}, bus.Data_2, b);
        chk({n, "_dest"}, bus.dest_reg, d);
        chk({n, "_cnt"}, issue_count, cnt);
    endtask

    typedef struct {
        logic [31:0] ins; logic [2:0] c; logic [31:0] b; logic [4:0] d; bit ill;
    } vec_t;

    initial begin
        vec_t vt[6];
        reset = 1; in_valid = 0; flush = 0; instr = 0; rs_data = 0; rt_data = 0;
        bus.out_ready = 1;
        @(posedge clk); @(posedge clk); #2;
        model_on = 1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_ctrl", bus.ALU_control, 2);
        chk("rst_cnt", issue_count, 0);
        reset = 0; #1;
        chk("post_rst_in_ready", in_ready, 1);

        // add $3,$1,$2
        drive(32'h00221820, 5, 7); cyc();
        expect_out("add", 3'd2, 5, 7, 5'd3, 1);
        // addi $4,$1,-1
        drive(32'h2024FFFF, 10, 0); cyc();
        expect_out("addi", 3'd2, 10, 32'hFFFFFFFF, 5'd4, 2);
        // ori $4,$1,0x8000
        drive(32'h34248000, 10, 0); cyc();
        expect_out("ori", 3'd1, 10, 32'h00008000, 5'd4, 3);

        // Back-pressure with sub $5,$1,$2 waiting
        drive(32'h00222822, 20, 3);
        bus.out_ready = 0; #1;
        chk("bp_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_in_ready_hold", in_ready, 0);
            expect_out("bp_hold", 3'd1, 10, 32'h00008000, 5'd4, 3);
        end
        bus.out_ready = 1; cyc();
        expect_out("sub", 3'd6, 20, 3, 5'd5, 4);
        in_valid = 0; cyc();
        chk("drain_valid", bus.out_valid, 0);
        chk("drain_hold_ctrl", bus.ALU_control, 6);

        // flush over a stalled op and an incoming op
        drive(32'h00221824, 1, 2); cyc();
        expect_out("and", 3'd0, 1, 2, 5'd3, 5);
        bus.out_ready = 0; flush = 1; drive(32'h00221825, 1, 2); cyc();
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_cnt", issue_count, 5);
        chk("flush_hold_ctrl", bus.ALU_control, 0);
        flush = 0; bus.out_ready = 1;

        // unsupported opcode -> bubble, then slt
        drive(32'hFC000000, 9, 9); cyc();
        expect_out("ill", 3'd2, 0, 0, 5'd0, 5);
        chk("ill_flag", bus.illegal, 1);
        drive(32'h0022182A, 4, 8); cyc();
        expect_out("slt", 3'd7, 4, 8, 5'd3, 6);
        chk("slt_flag", bus.illegal, 0);

        // remaining I-type forms plus an unsupported R-type funct
        vt[0] = '{32'hAC220004, 3'd2, 32'h00000004, 5'd0, 0};   // sw
        vt[1] = '{32'h10220003, 3'd6, 32'h00000011, 5'd0, 0};   // beq
        vt[2] = '{32'h3022FFFF, 3'd0, 32'h0000FFFF, 5'd2, 0};   // andi
        vt[3] = '{32'h2822FFFE, 3'd7, 32'hFFFFFFFE, 5'd2, 0};   // slti
        vt[4] = '{32'h8C220010, 3'd2, 32'h00000010, 5'd2, 0};   // lw
        vt[5] = '{32'h00000000, 3'd2, 32'h00000000, 5'd0, 1};   // sll
        for (int i = 0; i < 6; i++) begin
            drive(vt[i].ins, 32'h33, 32'h11); cyc();
            chk("tbl_ctrl", bus.ALU_control, vt[i].c);
            chk("tbl_d2", bus.Data_2, vt[i].b);
            chk("tbl_dest", bus.dest_reg, vt[i].d);
            chk("tbl_ill", bus.illegal, vt[i].ill);
            chk("tbl_rd1", bus.Read_data_1, vt[i].ill ? 32'h0 : 32'h33);
        end
        chk("tbl_cnt", issue_count, 11);

        // bring count to 14, then 3 more legal ops must stick at 15
        for (int i = 0; i < 3; i++) begin drive(32'h00221820, i, i); cyc(); end
        chk("cnt14", issue_count, 14);
        for (int i = 0; i < 3; i++) begin drive(32'h00221820, i, i); cyc(); end
        chk("cnt_sat", issue_count, 15);

        // reset while stalled
        bus.out_ready = 0; drive(32'h00221822, 1, 1); cyc();
        chk("stall_valid", bus.out_valid, 1);
        reset = 1; cyc();
        chk("rst2_valid", bus.out_valid, 0);
        chk("rst2_ctrl", bus.ALU_control, 2);
        chk("rst2_rd1", bus.Read_data_1, 0);
        chk("rst2_d2", bus.Data_2, 0);
        chk("rst2_dest", bus.dest_reg, 0);
        chk("rst2_ill", bus.illegal, 0);
        chk("rst2_cnt", issue_count, 0);
        chk("rst2_in_ready", in_ready, 0);
        reset = 0; in_valid = 0; cyc();
        chk("rst2_after_in_ready", in_ready, 1);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX issue stage that drives the ALU's operand and control inputs: it is the initiator side of the Read_data_1/Data_2/ALU_control interface.
- Decodes a MIPS instruction plus register-file read data into a 3-bit ALU_control code and the two ALU operands.
- Registers the result in a valid/ready pipeline slot with stall and flush support.
- Keeps a saturating count of issued operations for debug.

Parameters:
- DATA_W, 32, operand width.
- CNT_W, 16, width of the issued-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  ID stage presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- instr  input  32  instruction word.
- rs_data  input  DATA_W  register-file read port 1.
- rt_data  input  DATA_W  register-file read port 2.
- flush  input  1  kill the held and incoming instruction (branch taken).
- out_valid  output  1  ALU-side outputs hold a live operation.
- out_ready  input  1  EX/MEM accepts this cycle.
- Read_data_1  output  DATA_W  ALU operand A.
- Data_2  output  DATA_W  ALU operand B (rt_data or extended immediate).
- ALU_control  output  3  0=AND, 1=OR, 2=ADD, 6=SUB, 7=SLT.
- dest_reg  output  5  writeback register (rd for R-type, rt for I-type, 0 for sw/beq).
- illegal  output  1  registered: decoded opcode/funct unsupported.
- issue_count  output  CNT_W  saturating count of accepted, non-flushed operations.

Behaviour:
- Reset values: out_valid=0, Read_data_1=0, Data_2=0, ALU_control=2, dest_reg=0, illegal=0, issue_count=0. in_ready=1 one cycle after reset deasserts; in_ready is 0 while reset is high.
- in_ready = !out_valid || out_ready (combinational).
- Accept when in_valid && in_ready && !flush. All outputs update on that edge (latency 1 cycle). out_valid<=1.
- When out_valid && out_ready and there is no accept, out_valid<=0. Data outputs hold their last value.
- When out_valid && !out_ready, all outputs hold stable, with no change at all until accepted.
- flush is priority over everything except reset:
  - out_valid<=0 and the incoming instruction is dropped.
  - illegal<=0.
  - Data outputs hold.
  - issue_count is not incremented.
- Simultaneous drain and accept (out_valid && out_ready && in_valid): the new operation replaces the old one in the same edge, and out_valid stays 1.
- Decode, R-type (opcode 0x00), by funct:
  - 0x20/0x21 -> 2.
  - 0x22/0x23 -> 6.
  - 0x24 -> 0.
  - 0x25 -> 1.
  - 0x2A -> 7.
  - For all of these, Data_2=rt_data and dest=rd.
- Decode, I-type:
  - lw 0x23 and sw 0x2B -> 2, sign-extended imm.
  - addi 0x08 -> 2, sign-extended.
  - slti 0x0A -> 7, sign-extended.
  - andi 0x0C -> 0, zero-extended.
  - ori 0x0D -> 1, zero-extended.
  - beq 0x04 -> 6 with Data_2=rt_data, dest=0.
  - I-type dest=rt; sw dest=0.
- Read_data_1 = rs_data for every op.
- Unsupported opcode/funct is still accepted as a bubble with illegal=1, ALU_control=2, Read_data_1=0, Data_2=0, dest_reg=0.
- illegal is valid only while out_valid=1.
- issue_count increments on each accept of a legal op and saturates at all-ones; it does not wrap.
- reset mid-stall discards the held operation and returns every output to its reset value.

Decomposition:
- Shared package alu_defs holds:
  - ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_SLT=7.
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI.
  - Funct constants: F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_SLT.
- One combinational sub-module, alu_ctrl_decode. It maps instr to alu_control, an imm_sel/zero_ext selector, a dest select and illegal.
- alu_issue_stage holds the pipeline register, the handshake and the counter.

Test Plan:
- Reset, then instr=add $3,$1,$2 (0x00221820), rs=5, rt=7, out_ready=1 -> next cycle out_valid=1, ALU_control=2, Read_data_1=5, Data_2=7, dest_reg=3, issue_count=1.
- addi $4,$1,-1 (0x2024FFFF), rs=10 -> ALU_control=2, Data_2=0xFFFFFFFF, dest_reg=4. Then ori $4,$1,0x8000 -> ALU_control=1, Data_2=0x00008000.
- Back-pressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs constant. Release -> the held op is consumed and the next op appears on the following edge with no loss or duplication.
- flush asserted with in_valid=1 and out_valid=1 -> next cycle out_valid=0, issue_count unchanged.
- Opcode 0x3F -> out_valid=1, illegal=1, ALU_control=2, operands 0, issue_count unchanged. Then slt funct 0x2A -> ALU_control=7, illegal=0.
- Force issue_count to all-ones minus 1 with CNT_W=4, then issue 3 legal ops -> count sticks at 15. Assert reset while stalled -> all outputs return to reset values on the next edge.
